pkt_classifier: RTL and testbench

- Registered, parametrised successor of the combinational packet parser for the N-port switch.
- Accepts one header (source and target port masks) per cycle over valid/ready and classifies it as SDP/MDP/BDP/ERR.
- Computes the legal destination mask and presents the result one cycle later over valid/ready toward the switch arbiter.
- Keeps saturating per-type statistics counters, with optional drop of illegal headers.

---
 rtl/pkt_classifier_pkg.sv | 61 ++++++
 rtl/pkt_classifier_if.sv | 31 +++
 rtl/pkt_classifier_sat_counter.sv | 25 ++
 rtl/pkt_classifier.sv | 100 ++++++++++
 tb/tb_pkt_classifier.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_classifier_pkg.sv
// Shared switch package: header classification type, port-count limit and
// the combinational classification rules used by the parser and classifier.
package pkt_classifier_pkg;

  localparam int N_PORTS_MAX = 16;

  typedef enum logic [1:0] {
    SDP = 2'd0,
    MDP = 2'd1,
    BDP = 2'd2,
    ERR = 2'd3
  } p_type;

  typedef struct packed {
    p_type                  ptype;
    logic                   legal;
    logic [N_PORTS_MAX-1:0] dest;
  } class_t;

  // Number of set bits in a port mask.
  function automatic logic [4:0] popcount(input logic [N_PORTS_MAX-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < N_PORTS_MAX; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Classify one header. Masks narrower than N_PORTS_MAX must be
  // zero-extended by the caller; n_ports is the active port count.
  function automatic class_t classify(input logic [N_PORTS_MAX-1:0] source,
                                      input logic [N_PORTS_MAX-1:0] target,
                                      input int                     n_ports);
    class_t     r;
    logic [4:0] k;
    logic [4:0] ks;
    k  = popcount(target);
    ks = popcount(source);
    if (k == 5'd0) begin
      r.ptype = ERR;
    end else if (k == 5'd1) begin
      r.ptype = SDP;
    end else if (k == 5'(n_ports)) begin
      r.ptype = BDP;
    end else begin
      r.ptype = MDP;
    end
    // Broadcast may include the source bit; everything else must not.
    r.legal = (ks == 5'd1) && (target != '0) && (r.ptype != ERR) &&
              (((target & source) == '0) || (r.ptype == BDP));
    if (r.legal) begin
      r.dest = target & ~source;
    end else begin
      r.ptype = ERR;
      r.dest  = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_classifier_if.sv
// Header-in / result-out handshake bundle of the packet classifier.
interface pkt_classifier_if
  import pkt_classifier_pkg::*;
#(
  parameter int N_PORTS = 4
) ();

  logic               in_valid;
  logic               in_ready;
  logic [N_PORTS-1:0] in_source;
  logic [N_PORTS-1:0] in_target;
  logic               out_valid;
  logic               out_ready;
  p_type              out_type;
  logic               out_legal;
  logic [N_PORTS-1:0] out_source;
  logic [N_PORTS-1:0] out_dest;

  // Classifier side.
  modport slave (
    input  in_valid, in_source, in_target, out_ready,
    output in_ready, out_valid, out_type, out_legal, out_source, out_dest
  );

  // Upstream source / downstream sink side.
  modport master (
    output in_valid, in_source, in_target, out_ready,
    input  in_ready, out_valid, out_type, out_legal, out_source, out_dest
  );

endinterface

// File: rtl/pkt_classifier_sat_counter.sv
// Saturating statistics counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count events, stick at all-ones, clear on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pkt_classifier.sv
// Registered packet classifier: one header per cycle in, classified result
// with destination mask one cycle later, plus per-type statistics.
module pkt_classifier
  import pkt_classifier_pkg::*;
#(
  parameter int N_PORTS  = 4,
  parameter int CNT_W    = 16,
  parameter int DROP_ERR = 1
) (
  input  logic                clk,
  input  logic                rst,
  pkt_classifier_if.slave     bus,
  input  logic                clear_stats,
  output logic [CNT_W-1:0]    cnt_sdp,
  output logic [CNT_W-1:0]    cnt_mdp,
  output logic [CNT_W-1:0]    cnt_bdp,
  output logic [CNT_W-1:0]    cnt_err
);

  logic [N_PORTS_MAX-1:0] source_ext_s;
  logic [N_PORTS_MAX-1:0] target_ext_s;
  logic [N_PORTS_MAX-1:0] unused_dest_s;
  class_t                 cls_s;
  logic                   in_ready_s;
  logic                   accept_s;
  logic                   transfer_s;
  logic                   load_s;
  logic                   inc_sdp_s;
  logic                   inc_mdp_s;
  logic                   inc_bdp_s;
  logic                   inc_err_s;

  logic                   valid_r;
  p_type                  type_r;
  logic                   legal_r;
  logic [N_PORTS-1:0]     source_r;
  logic [N_PORTS-1:0]     dest_r;

  // Classify the incoming header and derive the handshake events.
  always_comb begin
    source_ext_s = '0;
    target_ext_s = '0;
    source_ext_s[N_PORTS-1:0] = bus.in_source;
    target_ext_s[N_PORTS-1:0] = bus.in_target;
    cls_s = classify(source_ext_s, target_ext_s, N_PORTS);
    // Upper destination bits are always zero for zero-extended masks.
    unused_dest_s = cls_s.dest;
    in_ready_s = !valid_r || bus.out_ready;
    accept_s   = bus.in_valid && in_ready_s;
    transfer_s = valid_r && bus.out_ready;
    // Dropped illegal headers are counted but never reach the register.
    load_s     = accept_s && (cls_s.legal || (DROP_ERR == 0));
    inc_sdp_s  = accept_s && (cls_s.ptype == SDP);
    inc_mdp_s  = accept_s && (cls_s.ptype == MDP);
    inc_bdp_s  = accept_s && (cls_s.ptype == BDP);
    inc_err_s  = accept_s && (cls_s.ptype == ERR);
  end

  // Single-stage output register: load on accept, empty on transfer, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r  <= 1'b0;
      type_r   <= ERR;
      legal_r  <= 1'b0;
      source_r <= '0;
      dest_r   <= '0;
    end else if (load_s) begin
      valid_r  <= 1'b1;
      type_r   <= cls_s.ptype;
      legal_r  <= cls_s.legal;
      source_r <= bus.in_source;
      dest_r   <= cls_s.dest[N_PORTS-1:0];
    end else if (transfer_s) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = valid_r;
  assign bus.out_type   = type_r;
  assign bus.out_legal  = legal_r;
  assign bus.out_source = source_r;
  assign bus.out_dest   = dest_r;

  sat_counter #(.CNT_W(CNT_W)) u_cnt_sdp (
    .clk(clk), .rst(rst), .inc(inc_sdp_s), .clr(clear_stats), .count(cnt_sdp)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_mdp (
    .clk(clk), .rst(rst), .inc(inc_mdp_s), .clr(clear_stats), .count(cnt_mdp)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_bdp (
    .clk(clk), .rst(rst), .inc(inc_bdp_s), .clr(clear_stats), .count(cnt_bdp)
  );
  sat_counter #(.CNT_W(CNT_W)) u_cnt_err (
    .clk(clk), .rst(rst), .inc(inc_err_s), .clr(clear_stats), .count(cnt_err)
  );

endmodule

// File: tb/tb_pkt_classifier.sv
// Bench for pkt_classifier: two instances driven in lockstep
// (A: CNT_W=16 DROP_ERR=1, B: CNT_W=2 DROP_ERR=0) against a reference model.
module tb_pkt_classifier;
  import pkt_classifier_pkg::*;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic [15:0] a_sdp, a_mdp, a_bdp, a_err;
  logic [1:0]  b_sdp, b_mdp, b_bdp, b_err;

  pkt_classifier_if #(.N_PORTS(NP)) bus_a ();
  pkt_classifier_if #(.N_PORTS(NP)) bus_b ();

  pkt_classifier #(.N_PORTS(NP), .CNT_W(16), .DROP_ERR(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .clear_stats(clr),
    .cnt_sdp(a_sdp), .cnt_mdp(a_mdp), .cnt_bdp(a_bdp), .cnt_err(a_err)
  );
  pkt_classifier #(.N_PORTS(NP), .CNT_W(2), .DROP_ERR(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .clear_stats(clr),
    .cnt_sdp(b_sdp), .cnt_mdp(b_mdp), .cnt_bdp(b_bdp), .cnt_err(b_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  bit          m_v   [2];
  p_type       m_t   [2];
  bit          m_l   [2];
  logic [NP-1:0] m_s [2];
  logic [NP-1:0] m_d [2];
  int          m_cnt [2][4];
  int          m_max [2] = '{65535, 3};
  bit          m_drop[2] = '{1'b1, 1'b0};
  logic [NP-1:0] log_q[$];

  typedef struct {
    logic [NP-1:0] src;
    logic [NP-1:0] tgt;
    p_type         ty;
    bit            lg;
    logic [NP-1:0] dst;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Classification straight from the rules: count bits, apply legality.
  function automatic void ref_cls(input logic [NP-1:0] s, input logic [NP-1:0] t,
                                  output p_type ty, output bit lg, output logic [NP-1:0] ds);
    int k;
    int ks;
    k  = $countones(t);
    ks = $countones(s);
    if (k == 0)       ty = ERR;
    else if (k == 1)  ty = SDP;
    else if (k == NP) ty = BDP;
    else              ty = MDP;
    lg = (ks == 1) && (ty != ERR) && (((t & s) == 4'b0000) || ty == BDP);
    if (!lg) ty = ERR;
    ds = lg ? (t & ~s) : 4'b0000;
  endfunction

  function automatic int cidx(input p_type ty);
    case (ty)
      SDP:     return 0;
      MDP:     return 1;
      BDP:     return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 1'b0; m_t[d] = ERR; m_l[d] = 1'b0; m_s[d] = '0; m_d[d] = '0;
      for (int j = 0; j < 4; j++) m_cnt[d][j] = 0;
    end
  endtask

  // One clock: drive, check both DUTs on the falling edge, advance the model.
  task automatic step(input bit v, input logic [NP-1:0] s, input logic [NP-1:0] t,
                      input bit ordy, input bit c, input bit r);
    bit            a_rdy, a_v, a_l, exp_rdy, acc, xf, lg;
    p_type         a_t, ty;
    logic [NP-1:0] a_s, a_d, ds;
    int            a_c[4];
    bus_a.in_valid = v; bus_a.in_source = s; bus_a.in_target = t; bus_a.out_ready = ordy;
    bus_b.in_valid = v; bus_b.in_source = s; bus_b.in_target = t; bus_b.out_ready = ordy;
    clr = c;
    rst = r;
    @(negedge clk);
    ref_cls(s, t, ty, lg, ds);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        a_rdy = bus_a.in_ready; a_v = bus_a.out_valid; a_t = bus_a.out_type;
        a_l = bus_a.out_legal; a_s = bus_a.out_source; a_d = bus_a.out_dest;
        a_c[0] = int'(a_sdp); a_c[1] = int'(a_mdp); a_c[2] = int'(a_bdp); a_c[3] = int'(a_err);
      end else begin
        a_rdy = bus_b.in_ready; a_v = bus_b.out_valid; a_t = bus_b.out_type;
        a_l = bus_b.out_legal; a_s = bus_b.out_source; a_d = bus_b.out_dest;
        a_c[0] = int'(b_sdp); a_c[1] = int'(b_mdp); a_c[2] = int'(b_bdp); a_c[3] = int'(b_err);
      end
      exp_rdy = !m_v[d] || ordy;
      chk($sformatf("dut%0d in_ready", d), int'(a_rdy), int'(exp_rdy));
      chk($sformatf("dut%0d out_valid", d), int'(a_v), int'(m_v[d]));
      if (m_v[d]) begin
        chk($sformatf("dut%0d out_type", d), int'(a_t), int'(m_t[d]));
        chk($sformatf("dut%0d out_legal", d), int'(a_l), int'(m_l[d]));
        chk($sformatf("dut%0d out_source", d), int'(a_s), int'(m_s[d]));
        chk($sformatf("dut%0d out_dest", d), int'(a_d), int'(m_d[d]));
      end
      for (int j = 0; j < 4; j++)
        chk($sformatf("dut%0d cnt[%0d]", d, j), a_c[j], m_cnt[d][j]);
      acc = v && exp_rdy;
      xf  = m_v[d] && ordy;
      if (!r) begin
        if (xf && d == 0) log_q.push_back(m_d[0]);
        if (c) begin
          for (int j = 0; j < 4; j++) m_cnt[d][j] = 0;
        end else if (acc && m_cnt[d][cidx(ty)] < m_max[d]) begin
          m_cnt[d][cidx(ty)]++;
        end
        if (acc && (lg || !m_drop[d])) begin
          m_v[d] = 1'b1; m_t[d] = ty; m_l[d] = lg; m_s[d] = s; m_d[d] = ds;
        end else if (xf) begin
          m_v[d] = 1'b0;
        end
      end
    end
    if (r) model_reset();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[11];
  logic [NP-1:0] rs, rt;

  initial begin
    vt[0]  = '{4'b0001, 4'b0100, SDP, 1'b1, 4'b0100};
    vt[1]  = '{4'b0010, 4'b1111, BDP, 1'b1, 4'b1101};
    vt[2]  = '{4'b0010, 4'b0110, ERR, 1'b0, 4'b0000};
    vt[3]  = '{4'b0011, 4'b0100, ERR, 1'b0, 4'b0000};
    vt[4]  = '{4'b0001, 4'b0000, ERR, 1'b0, 4'b0000};
    vt[5]  = '{4'b1000, 4'b0111, MDP, 1'b1, 4'b0111};
    vt[6]  = '{4'b0100, 4'b1111, BDP, 1'b1, 4'b1011};
    vt[7]  = '{4'b0001, 4'b0011, ERR, 1'b0, 4'b0000};
    vt[8]  = '{4'b0000, 4'b0001, ERR, 1'b0, 4'b0000};
    vt[9]  = '{4'b1000, 4'b1000, ERR, 1'b0, 4'b0000};
    vt[10] = '{4'b0100, 4'b0011, MDP, 1'b1, 4'b0011};

    // Initial reset, then the reset state.
    bus_a.in_valid = 1'b0; bus_a.in_source = '0; bus_a.in_target = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_source = '0; bus_b.in_target = '0; bus_b.out_ready = 1'b0;
    clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("reset out_valid", int'(bus_a.out_valid), 0);
    chk("reset out_type", int'(bus_a.out_type), int'(ERR));
    chk("reset out_legal", int'(bus_a.out_legal), 0);
    chk("reset out_source", int'(bus_a.out_source), 0);
    chk("reset out_dest", int'(bus_a.out_dest), 0);
    chk("reset in_ready", int'(bus_a.in_ready), 1);
    chk("reset cnt_sdp", int'(a_sdp), 0);
    chk("reset cnt_err", int'(a_err), 0);

    // Table vectors, one header per cycle with out_ready=1.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, vt[i].src, vt[i].tgt, 1'b1, 1'b0, 1'b0);
      chk($sformatf("vec%0d B valid", i), int'(bus_b.out_valid), 1);
      chk($sformatf("vec%0d B type", i), int'(bus_b.out_type), int'(vt[i].ty));
      chk($sformatf("vec%0d B legal", i), int'(bus_b.out_legal), int'(vt[i].lg));
      chk($sformatf("vec%0d B dest", i), int'(bus_b.out_dest), int'(vt[i].dst));
      chk($sformatf("vec%0d A valid", i), int'(bus_a.out_valid), int'(vt[i].lg));
      if (vt[i].lg) begin
        chk($sformatf("vec%0d A type", i), int'(bus_a.out_type), int'(vt[i].ty));
        chk($sformatf("vec%0d A dest", i), int'(bus_a.out_dest), int'(vt[i].dst));
      end
    end
    chk("table cnt_err", int'(a_err), 6);
    chk("table cnt_bdp", int'(a_bdp), 2);
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);

    // Backpressure: three MDP headers, sink stalled for three cycles.
    log_q.delete();
    step(1'b1, 4'b0001, 4'b0110, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0010, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("bp in_ready low", int'(bus_a.in_ready), 0);
    step(1'b1, 4'b0010, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("bp dest held", int'(bus_a.out_dest), 4'b0110);
    step(1'b1, 4'b0010, 4'b1001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 4'b1011, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp beats", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("bp beat0", int'(log_q[0]), 4'b0110);
      chk("bp beat1", int'(log_q[1]), 4'b1001);
      chk("bp beat2", int'(log_q[2]), 4'b1011);
    end
    chk("bp cnt_mdp", int'(a_mdp), 3);

    // Saturation on the 2-bit counters, then clear racing an accept.
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0001, 4'b1000, 1'b1, 1'b0, 1'b0);
    chk("sat B cnt_sdp", int'(b_sdp), 3);
    chk("sat A cnt_sdp", int'(a_sdp), 5);
    step(1'b1, 4'b0001, 4'b1000, 1'b1, 1'b1, 1'b0);
    chk("clr B cnt_sdp", int'(b_sdp), 0);
    chk("clr A cnt_sdp", int'(a_sdp), 0);
    chk("clr keeps data", int'(bus_a.out_valid), 1);

    // Reset while a result is held under backpressure.
    step(1'b1, 4'b0010, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'b0100, 4'b0001, 1'b0, 1'b1, 1'b1);
    chk("rst out_valid", int'(bus_a.out_valid), 0);
    chk("rst in_ready", int'(bus_a.in_ready), 1);
    chk("rst cnt_sdp", int'(a_sdp), 0);
    chk("rst B out_valid", int'(bus_b.out_valid), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 1) == 0) ? 4'(1 << $urandom_range(0, NP - 1)) : 4'($urandom);
      rt = 4'($urandom);
      step($urandom_range(0, 3) != 0, rs, rt, $urandom_range(0, 2) != 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 399) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
